// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between two cache controllers
module mem_arbiter #(
    parameter int BUS_WIDTH      = 32,
    parameter int Address_WIDTH  = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_Req0Read,
    input  logic                     i_Req0Write,
    input  logic [Address_WIDTH-1:0] i_Req0Address,
    input  logic [BUS_WIDTH-1:0]     i_Req0WriteData,
    input  logic                     i_Req1Read,
    input  logic                     i_Req1Write,
    input  logic [Address_WIDTH-1:0] i_Req1Address,
    input  logic [BUS_WIDTH-1:0]     i_Req1WriteData,
    output logic                     o_Ready0,
    output logic                     o_Ready1,
    output logic [BUS_WIDTH-1:0]     o_ReadData,
    output logic                     o_Error,
    output logic                     o_MemRead,
    output logic                     o_MemWrite,
    output logic [Address_WIDTH-1:0] o_MemAddress,
    output logic [BUS_WIDTH-1:0]     o_MemWriteData,
    input  logic                     i_MemReady,
    input  logic [BUS_WIDTH-1:0]     i_MemReadData,
    output logic [1:0]               o_Grant,
    output logic                     o_Busy
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        s_IDLE   = 3'b001,
        s_ACCESS = 3'b010,
        s_DONE   = 3'b100
    } state_t;

    state_t                   state, state_d;
    logic                     r_last, last_d;
    logic [WD_W-1:0]          r_wdog, wdog_d;
    logic [1:0]               grant_d;
    logic                     rd_d, wr_d, rdy0_d, rdy1_d, err_d, busy_d;
    logic [Address_WIDTH-1:0] addr_d;
    logic [BUS_WIDTH-1:0]     wdata_d, rdata_d;

    logic pend0, pend1, pick1, timeout_hit;

    assign pend0       = i_Req0Read | i_Req0Write;
    assign pend1       = i_Req1Read | i_Req1Write;
    // r_last == 0 means req0 went last, so req1 takes a tie
    assign pick1       = pend1 & (~pend0 | ~r_last);
    // abort on the edge that closes the TIMEOUT_CYCLES-th stalled ACCESS cycle
    assign timeout_hit = (r_wdog >= WD_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= s_IDLE;
            r_last         <= 1'b1;
            r_wdog         <= '0;
            o_Grant        <= '0;
            o_MemRead      <= 1'b0;
            o_MemWrite     <= 1'b0;
            o_MemAddress   <= '0;
            o_MemWriteData <= '0;
            o_ReadData     <= '0;
            o_Ready0       <= 1'b0;
            o_Ready1       <= 1'b0;
            o_Error        <= 1'b0;
            o_Busy         <= 1'b0;
        end else begin
            state          <= state_d;
            r_last         <= last_d;
            r_wdog         <= wdog_d;
            o_Grant        <= grant_d;
            o_MemRead      <= rd_d;
            o_MemWrite     <= wr_d;
            o_MemAddress   <= addr_d;
            o_MemWriteData <= wdata_d;
            o_ReadData     <= rdata_d;
            o_Ready0       <= rdy0_d;
            o_Ready1       <= rdy1_d;
            o_Error        <= err_d;
            o_Busy         <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            s_IDLE:   if (pend0 || pend1) state_d = s_ACCESS;
            s_ACCESS: if (i_MemReady || timeout_hit) state_d = s_DONE;
            s_DONE:   state_d = s_IDLE;
            default:  state_d = s_IDLE;
        endcase
    end

    always_comb begin
        last_d  = r_last;
        wdog_d  = r_wdog;
        grant_d = o_Grant;
        rd_d    = o_MemRead;
        wr_d    = o_MemWrite;
        addr_d  = o_MemAddress;
        wdata_d = o_MemWriteData;
        rdata_d = o_ReadData;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_d != s_IDLE);
        case (state)
            s_IDLE: begin
                if (pend0 || pend1) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    addr_d  = pick1 ? i_Req1Address : i_Req0Address;
                    wdata_d = pick1 ? i_Req1WriteData : i_Req0WriteData;
                    // write-back precedes allocate when both ops are requested
                    wr_d    = pick1 ? i_Req1Write : i_Req0Write;
                    rd_d    = pick1 ? (i_Req1Read & ~i_Req1Write) : (i_Req0Read & ~i_Req0Write);
                    wdog_d  = '0;
                end
            end
            s_ACCESS: begin
                if (i_MemReady || timeout_hit) begin
                    if (i_MemReady && o_MemRead) rdata_d = i_MemReadData;
                    err_d   = ~i_MemReady;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    grant_d = '0;
                    rdy0_d  = o_Grant[0];
                    rdy1_d  = o_Grant[1];
                end else if (r_wdog < WD_MAX) begin
                    wdog_d = r_wdog + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single main-memory port between the instruction-side and data-side cache controllers. It accepts level requests (read or write) from each side, grants one at a time with round-robin priority, drives the memory strobes/address/data for the winner, and returns a one-cycle ready pulse with latched read data. A watchdog aborts any access whose memory handshake stalls, so no requester can hang forever.

## Interface
- BUS_WIDTH, 32, data word width on all data buses
- Address_WIDTH, 10, address width on all address buses
- TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before abort (1..2^16-1)
- i_clk  in  1  rising-edge clock
- i_reset  in  1  synchronous, active-high reset
- i_Req0Read / i_Req0Write  in  1 / 1  requester 0 (instruction side) read / write request, held until o_Ready0
- i_Req0Address  in  Address_WIDTH  requester 0 address
- i_Req0WriteData  in  BUS_WIDTH  requester 0 write data
- i_Req1Read / i_Req1Write  in  1 / 1  requester 1 (data side), same rules
- i_Req1Address  in  Address_WIDTH  requester 1 address
- i_Req1WriteData  in  BUS_WIDTH  requester 1 write data
- o_Ready0 / o_Ready1  out  1 / 1  one-cycle completion pulse to the granted requester
- o_ReadData  out  BUS_WIDTH  read data latched on completion, shared by both requesters
- o_Error  out  1  pulses with ready when the access was aborted by the watchdog
- o_MemRead / o_MemWrite  out  1 / 1  memory strobes, level, held for the whole access
- o_MemAddress  out  Address_WIDTH  memory address
- o_MemWriteData  out  BUS_WIDTH  memory write data
- i_MemReady  in  1  memory completion, sampled only in ACCESS
- i_MemReadData  in  BUS_WIDTH  memory read data, valid when i_MemReady is high
- o_Grant  out  2  one-hot current owner (bit0 = req0, bit1 = req1), 0 when idle
- o_Busy  out  1  high in ACCESS and DONE

## Operation
- States: s_IDLE, s_ACCESS, s_DONE (one-hot encoding).
- s_IDLE: requester X is pending if ReqXRead or ReqXWrite. None pending -> stay. One pending -> grant it. Both pending -> grant the one not equal to r_last (round-robin). On grant: register owner into o_Grant, update r_last, latch address, write data, and op into o_MemAddress/o_MemWriteData/o_MemRead/o_MemWrite, clear watchdog, -> s_ACCESS.
- Read and Write both high from the same requester: write wins (o_MemWrite=1, o_MemRead=0); write-back precedes allocate.
- s_ACCESS: strobes, address, and data held constant. i_MemReady=1 -> latch i_MemReadData into o_ReadData (reads only; unchanged on writes), drop strobes, pulse owner's o_ReadyX, -> s_DONE. Otherwise increment watchdog; when the count reaches TIMEOUT_CYCLES with no ready -> drop strobes, pulse o_ReadyX and o_Error, leave o_ReadData unchanged, -> s_DONE.
- s_DONE: one turnaround cycle; o_Grant cleared; all requests ignored (the owner deasserts its request here) -> s_IDLE.
- Request inputs and request changes during s_ACCESS are ignored; the latched access completes regardless.
- The watchdog is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
- i_MemReady outside s_ACCESS is ignored.

## Timing
- Reset (i_reset high at an edge, any state, including mid-access): state s_IDLE; o_Ready0/1, o_Error, o_MemRead, o_MemWrite, o_Busy = 0; o_Grant = 0; o_MemAddress, o_MemWriteData, o_ReadData = 0; watchdog = 0; r_last = 1 (req0 wins the first tie). An in-flight memory access is dropped with no ready pulse.
- All outputs are registered; no combinational input-to-output paths.
- Request sampled at edge N (in s_IDLE) -> strobes valid after edge N, i.e. during cycle N+1.
- i_MemReady sampled high at edge M -> o_ReadyX/o_ReadData valid during cycle M+1 (1 cycle wide); s_IDLE at M+2; next grant earliest with strobes valid during M+3.
- Zero-wait memory (ready in the first ACCESS cycle): request-to-ready = 2 cycles; back-to-back throughput = one access per 3 cycles.
- Timeout: strobes are held for exactly TIMEOUT_CYCLES cycles, then o_Error and o_ReadyX pulse in the next cycle.

## Test plan
- Single read, req0, addr 0x155, memory ready after 3 cycles with data 0xDEADBEEF -> o_MemRead high 3 cycles with o_MemAddress=0x155, o_Grant=01; o_Ready0 1-cycle pulse, o_ReadData=0xDEADBEEF, o_Ready1 stays 0.
- Simultaneous req0 read 0x010 and req1 write 0x020 of data 0x12345678 from reset -> req0 served first; then req1 with o_MemWrite=1, o_MemWriteData=0x12345678; next tie goes to req0 again (strict alternation over 4 ties).
- req1 asserts Read and Write together at 0x3FF -> only o_MemWrite=1; o_ReadData unchanged after the ready pulse.
- TIMEOUT_CYCLES=4, i_MemReady held 0 -> strobe high exactly 4 cycles; then o_Ready0 and o_Error pulse together; back in s_IDLE 2 cycles later.
- i_reset asserted in the 2nd ACCESS cycle of a write -> next cycle all outputs 0, no ready pulse; a subsequent tie is granted to req0.
- i_MemReady pulsed while idle, and req0 dropping its request mid-access -> no spurious ready; the in-flight access completes normally with one o_Ready0 pulse.
